// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
// The deframer FSM states and the default frame geometry live here.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_deframer_if.sv
// Serial-in / frame-out bundle between a UART line source and the deframer.
// The slave modport is the deframer side; the master modport drives the line.
interface uart_rx_deframer_if #(
    parameter int DATA_BITS = 8
);
    logic                 baud_tick;
    logic                 rx_in;
    logic [DATA_BITS-1:0] data_sipo;
    logic                 parity_in;
    logic                 parity_load;
    logic                 stop_error;
    logic                 busy;

    modport slave (
        input  baud_tick, rx_in,
        output data_sipo, parity_in, parity_load, stop_error, busy
    );

    modport master (
        output baud_tick, rx_in,
        input  data_sipo, parity_in, parity_load, stop_error, busy
    );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous level, resetting to 1 (idle line).
// Also used for the TX-side CTS input.
module uart_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: qualifies the start bit at mid-bit, shifts in data LSB-first,
// captures parity, checks stop, then presents the frame with a one-clk parity_load strobe.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input logic                 clk,
    input logic                 rst_n,
    uart_rx_deframer_if.slave   bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 w_rx_s;
    uart_rx_state_t       r_state;
    logic [TW-1:0]        r_tick_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 r_parity;
    logic [DATA_BITS-1:0] r_data_sipo;
    logic                 r_parity_in;
    logic                 r_parity_load;
    logic                 r_stop_error;
    logic                 r_busy;

    uart_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (bus.rx_in),
        .o_q   (w_rx_s)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_tick_cnt    <= '0;
            r_bit_cnt     <= '0;
            r_shreg       <= '0;
            r_parity      <= 1'b0;
            r_data_sipo   <= '0;
            r_parity_in   <= 1'b0;
            r_parity_load <= 1'b0;
            r_stop_error  <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_parity_load <= 1'b0;
            if (bus.baud_tick) begin
                unique case (r_state)
                    IDLE: begin
                        if (!w_rx_s) begin
                            r_state    <= START;
                            r_tick_cnt <= '0;
                            r_busy     <= 1'b1;
                        end
                    end
                    START: begin
                        // A start bit that is high again at its midpoint is a glitch.
                        if (r_tick_cnt == HALF_LAST) begin
                            r_tick_cnt <= '0;
                            if (!w_rx_s) begin
                                r_state   <= DATA;
                                r_bit_cnt <= '0;
                            end else begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (r_tick_cnt == FULL_LAST) begin
                            r_tick_cnt <= '0;
                            r_shreg    <= {w_rx_s, r_shreg[DATA_BITS-1:1]};
                            r_bit_cnt  <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == BIT_LAST) r_state <= PARITY;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        if (r_tick_cnt == FULL_LAST) begin
                            r_tick_cnt <= '0;
                            r_parity   <= w_rx_s;
                            r_state    <= STOP;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        // Frames with a bad stop bit are still delivered, flagged.
                        if (r_tick_cnt == FULL_LAST) begin
                            r_tick_cnt    <= '0;
                            r_stop_error  <= ~w_rx_s;
                            r_data_sipo   <= r_shreg;
                            r_parity_in   <= r_parity;
                            r_parity_load <= 1'b1;
                            r_state       <= IDLE;
                            r_busy        <= 1'b0;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.data_sipo   = r_data_sipo;
    assign bus.parity_in   = r_parity_in;
    assign bus.parity_load = r_parity_load;
    assign bus.stop_error  = r_stop_error;
    assign bus.busy        = r_busy;
endmodule
